// File: rtl/fb_arbiter_pkg.sv
// Shared constants and types for the framebuffer access arbiter.
//   FB_ADDR_W / FB_DATA_W / FB_MASK_W : framebuffer access port field widths
//   TMO_CNT_W                        : width of the saturating timeout counter
//   arb_state_t                      : arbiter FSM state encoding
package fb_arbiter_pkg;

    localparam int unsigned FB_ADDR_W = 24;
    localparam int unsigned FB_DATA_W = 16;
    localparam int unsigned FB_MASK_W = 4;
    localparam int unsigned TMO_CNT_W = 13;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

endpackage

// File: rtl/fb_access_arbiter_if.sv
// Bundle of requester-side and framebuffer-side signals around the arbiter.
//   m_*      : per-requester sel/wr/mask/address/data in, shared read data and ack out
//   fb_*     : single framebuffer random-access port
//   grant_o  : index of the current/last granted requester (debug)
//   err_timeout_o : sticky downstream-timeout flag
// Modport slave is the arbiter's view, master is the environment's view.
interface fb_access_arbiter_if
    import fb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2
);
    logic [NUM_MASTERS-1:0]                m_sel_i;
    logic [NUM_MASTERS-1:0]                m_wr_i;
    logic [NUM_MASTERS-1:0][FB_MASK_W-1:0] m_mask_i;
    logic [NUM_MASTERS-1:0][FB_ADDR_W-1:0] m_address_i;
    logic [NUM_MASTERS-1:0][FB_DATA_W-1:0] m_data_in_i;
    logic [FB_DATA_W-1:0]                  m_data_out_o;
    logic [NUM_MASTERS-1:0]                m_ack_o;

    logic                                  fb_sel_o;
    logic                                  fb_wr_o;
    logic [FB_MASK_W-1:0]                  fb_mask_o;
    logic [FB_ADDR_W-1:0]                  fb_address_o;
    logic [FB_DATA_W-1:0]                  fb_data_o;
    logic                                  fb_ack_i;
    logic [FB_DATA_W-1:0]                  fb_data_i;

    logic [1:0]                            grant_o;
    logic                                  err_timeout_o;

    modport slave (
        input  m_sel_i, m_wr_i, m_mask_i, m_address_i, m_data_in_i, fb_ack_i, fb_data_i,
        output m_data_out_o, m_ack_o, fb_sel_o, fb_wr_o, fb_mask_o, fb_address_o, fb_data_o,
        output grant_o, err_timeout_o
    );

    modport master (
        output m_sel_i, m_wr_i, m_mask_i, m_address_i, m_data_in_i, fb_ack_i, fb_data_i,
        input  m_data_out_o, m_ack_o, fb_sel_o, fb_wr_o, fb_mask_o, fb_address_o, fb_data_o,
        input  grant_o, err_timeout_o
    );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin picker for up to four requesters.
//   req   : request vector
//   last  : index granted last time; the search starts at last+1 (mod NUM_MASTERS)
//   valid : at least one request present
//   idx   : winning requester index
module rr_select #(
    parameter int unsigned NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             last,
    output logic                   valid,
    output logic [1:0]             idx
);

    // Zero-extended copy so a 2-bit index always fits, whatever NUM_MASTERS is.
    logic [3:0] req_ext;
    logic [1:0] cand;

    assign req_ext = 4'(req);

    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            cand = 2'((32'(last) + 32'd1 + i) % NUM_MASTERS);
            if (!valid && req_ext[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// Round-robin arbiter sharing the framebuffer random-access port between requesters.
// One transaction in flight; each requester sees a plain sel/ack handshake.
//   clk     : framebuffer access clock
//   reset_i : synchronous active-high reset
//   bus     : requester and framebuffer signals (slave modport)
module fb_access_arbiter
    import fb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input logic                 clk,
    input logic                 reset_i,
    fb_access_arbiter_if.slave  bus
);

    arb_state_t             state_q, state_d;
    logic [1:0]             last_grant_q, last_grant_d;
    logic [1:0]             grant_q, grant_d;
    logic                   fb_sel_q, fb_sel_d;
    logic                   fb_wr_q, fb_wr_d;
    logic [FB_MASK_W-1:0]   fb_mask_q, fb_mask_d;
    logic [FB_ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [FB_DATA_W-1:0]   fb_data_q, fb_data_d;
    logic [NUM_MASTERS-1:0] ack_q, ack_d;
    logic [FB_DATA_W-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [TMO_CNT_W-1:0]   tmo_q, tmo_d;

    logic                   win_valid;
    logic [1:0]             win_idx;
    logic [TMO_CNT_W-1:0]   tmo_inc;
    logic                   tmo_hit;

    rr_select #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_rr_select (
        .req   (bus.m_sel_i),
        .last  (last_grant_q),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Saturating increment; abort fires on the BUSY cycle that brings the count to the limit.
    assign tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + 13'd1;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (32'(tmo_inc) == TIMEOUT_CYCLES);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        fb_sel_d     = fb_sel_q;
        fb_wr_d      = fb_wr_q;
        fb_mask_d    = fb_mask_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        ack_d        = '0;
        rdata_d      = rdata_q;
        err_d        = err_q;
        tmo_d        = tmo_q;

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                        if (win_idx == 2'(i)) begin
                            fb_wr_d   = bus.m_wr_i[i];
                            fb_mask_d = bus.m_mask_i[i];
                            fb_addr_d = bus.m_address_i[i];
                            fb_data_d = bus.m_data_in_i[i];
                        end
                    end
                    fb_sel_d     = 1'b1;
                    last_grant_d = win_idx;
                    grant_d      = win_idx;
                    tmo_d        = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (bus.fb_ack_i || tmo_hit) begin
                    fb_sel_d = 1'b0;
                    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
                        if (grant_q == 2'(i)) begin
                            ack_d[i] = 1'b1;
                        end
                    end
                    if (bus.fb_ack_i) begin
                        if (!fb_wr_q) begin
                            rdata_d = bus.fb_data_i;
                        end
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                    state_d = RELEASE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            RELEASE: begin
                // Gives the acked requester a cycle to drop sel before arbitration resumes.
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                fb_sel_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q      <= IDLE;
            last_grant_q <= 2'(NUM_MASTERS - 1);
            grant_q      <= 2'd0;
            fb_sel_q     <= 1'b0;
            fb_wr_q      <= 1'b0;
            fb_mask_q    <= '0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            fb_sel_q     <= fb_sel_d;
            fb_wr_q      <= fb_wr_d;
            fb_mask_q    <= fb_mask_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign bus.fb_sel_o      = fb_sel_q;
    assign bus.fb_wr_o       = fb_wr_q;
    assign bus.fb_mask_o     = fb_mask_q;
    assign bus.fb_address_o  = fb_addr_q;
    assign bus.fb_data_o     = fb_data_q;
    assign bus.m_ack_o       = ack_q;
    assign bus.m_data_out_o  = rdata_q;
    assign bus.grant_o       = grant_q;
    assign bus.err_timeout_o = err_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with two requesters and a 16-cycle timeout.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_fb_access_arbiter;

    logic clk;
    logic reset_i;
    int   total;
    int   bad;

    fb_access_arbiter_if #(.NUM_MASTERS(2)) bus ();

    fb_access_arbiter #(
        .NUM_MASTERS    (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.m_sel_i     = '0;
        bus.m_wr_i      = '0;
        bus.m_mask_i    = '0;
        bus.m_address_i = '0;
        bus.m_data_in_i = '0;
        bus.fb_ack_i    = 1'b0;
        bus.fb_data_i   = '0;
        reset_i         = 1'b1;
        step();
        step();
        total++; if (bus.fb_sel_o !== 1'b0) begin bad++;
            $display("FAIL reset_fb_sel: got %0b want 0", bus.fb_sel_o); end
        total++; if (bus.fb_wr_o !== 1'b0 || bus.fb_mask_o !== 4'h0) begin bad++;
            $display("FAIL reset_fb_wr_mask: got %0b/%h want 0/0", bus.fb_wr_o, bus.fb_mask_o); end
        total++; if (bus.fb_address_o !== 24'h0 || bus.fb_data_o !== 16'h0) begin bad++;
            $display("FAIL reset_fb_addr_data: got %h/%h want 0/0", bus.fb_address_o,
                     bus.fb_data_o); end
        total++; if (bus.m_ack_o !== 2'b00 || bus.m_data_out_o !== 16'h0) begin bad++;
            $display("FAIL reset_ack_data: got %b/%h want 00/0000", bus.m_ack_o,
                     bus.m_data_out_o); end
        total++; if (bus.grant_o !== 2'd0 || bus.err_timeout_o !== 1'b0) begin bad++;
            $display("FAIL reset_grant_err: got %0d/%0b want 0/0", bus.grant_o,
                     bus.err_timeout_o); end
        reset_i      = 1'b0;
        bus.fb_ack_i = 1'b1;
        step();
        total++; if (bus.m_ack_o !== 2'b00 || bus.fb_sel_o !== 1'b0) begin bad++;
            $display("FAIL idle_ack_ignored: got ack=%b sel=%0b want 00/0", bus.m_ack_o,
                     bus.fb_sel_o); end
        bus.fb_ack_i = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        bus.m_sel_i[0]     = 1'b1;
        bus.m_wr_i[0]      = 1'b1;
        bus.m_mask_i[0]    = 4'hF;
        bus.m_address_i[0] = 24'h000010;
        bus.m_data_in_i[0] = 16'hBEEF;
        total++; if (bus.fb_sel_o !== 1'b0) begin bad++;
            $display("FAIL wr_sel_before_edge: got %0b want 0", bus.fb_sel_o); end
        step();
        total++; if (bus.fb_sel_o !== 1'b1 || bus.fb_wr_o !== 1'b1) begin bad++;
            $display("FAIL wr_fb_sel_wr: got %0b/%0b want 1/1", bus.fb_sel_o, bus.fb_wr_o); end
        total++; if (bus.fb_address_o !== 24'h000010 || bus.fb_data_o !== 16'hBEEF) begin bad++;
            $display("FAIL wr_fb_fields: got %h/%h want 000010/beef", bus.fb_address_o,
                     bus.fb_data_o); end
        total++; if (bus.fb_mask_o !== 4'hF || bus.grant_o !== 2'd0) begin bad++;
            $display("FAIL wr_mask_grant: got %h/%0d want f/0", bus.fb_mask_o, bus.grant_o); end
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.m_ack_o !== 2'b00 || bus.fb_sel_o !== 1'b1) begin bad++;
                $display("FAIL wr_wait_%0d: got ack=%b sel=%0b want 00/1", i, bus.m_ack_o,
                         bus.fb_sel_o); end
        end
        bus.fb_ack_i  = 1'b1;
        bus.fb_data_i = 16'h7777;
        step();
        total++; if (bus.m_ack_o !== 2'b01 || bus.fb_sel_o !== 1'b0) begin bad++;
            $display("FAIL wr_ack: got ack=%b sel=%0b want 01/0", bus.m_ack_o, bus.fb_sel_o); end
        total++; if (bus.m_data_out_o !== 16'h0000) begin bad++;
            $display("FAIL wr_data_unchanged: got %h want 0000", bus.m_data_out_o); end
        bus.fb_ack_i   = 1'b0;
        bus.m_sel_i[0] = 1'b0;
        step();
        total++; if (bus.m_ack_o !== 2'b00) begin bad++;
            $display("FAIL wr_ack_one_cycle: got %b want 00", bus.m_ack_o); end
        step();
    endtask

    task automatic test_read_return();
        bus.m_sel_i        = 2'b10;
        bus.m_wr_i[1]      = 1'b0;
        bus.m_mask_i[1]    = 4'h3;
        bus.m_address_i[1] = 24'h000020;
        bus.m_data_in_i[1] = 16'h5A5A;
        step();
        total++; if (bus.fb_sel_o !== 1'b1 || bus.fb_wr_o !== 1'b0 || bus.grant_o !== 2'd1)
            begin bad++;
            $display("FAIL rd_grant: got sel=%0b wr=%0b grant=%0d want 1/0/1", bus.fb_sel_o,
                     bus.fb_wr_o, bus.grant_o); end
        total++; if (bus.fb_address_o !== 24'h000020 || bus.fb_mask_o !== 4'h3 ||
                     bus.fb_data_o !== 16'h5A5A) begin bad++;
            $display("FAIL rd_fields: got %h/%h/%h want 000020/3/5a5a", bus.fb_address_o,
                     bus.fb_mask_o, bus.fb_data_o); end
        step();
        step();
        bus.fb_ack_i  = 1'b1;
        bus.fb_data_i = 16'h1234;
        step();
        total++; if (bus.m_ack_o !== 2'b10 || bus.m_data_out_o !== 16'h1234) begin bad++;
            $display("FAIL rd_ack_data: got %b/%h want 10/1234", bus.m_ack_o,
                     bus.m_data_out_o); end
        bus.fb_ack_i = 1'b0;
        bus.m_sel_i  = 2'b00;
        step();
        total++; if (bus.m_ack_o !== 2'b00 || bus.m_data_out_o !== 16'h1234) begin bad++;
            $display("FAIL rd_after: got %b/%h want 00/1234", bus.m_ack_o, bus.m_data_out_o); end
    endtask

    task automatic test_timeout();
        bus.m_sel_i   = 2'b01;
        bus.m_wr_i[0] = 1'b1;
        step();
        total++; if (bus.fb_sel_o !== 1'b1 || bus.grant_o !== 2'd0) begin bad++;
            $display("FAIL tmo_grant: got sel=%0b grant=%0d want 1/0", bus.fb_sel_o,
                     bus.grant_o); end
        for (int i = 1; i <= 15; i++) begin
            step();
            total++; if (bus.m_ack_o !== 2'b00 || bus.fb_sel_o !== 1'b1 ||
                         bus.err_timeout_o !== 1'b0) begin bad++;
                $display("FAIL tmo_busy_%0d: got ack=%b sel=%0b err=%0b want 00/1/0", i,
                         bus.m_ack_o, bus.fb_sel_o, bus.err_timeout_o); end
        end
        step();
        total++; if (bus.m_ack_o !== 2'b01 || bus.m_data_out_o !== 16'h0000) begin bad++;
            $display("FAIL tmo_ack: got %b/%h want 01/0000", bus.m_ack_o, bus.m_data_out_o); end
        total++; if (bus.err_timeout_o !== 1'b1 || bus.fb_sel_o !== 1'b0) begin bad++;
            $display("FAIL tmo_err: got err=%0b sel=%0b want 1/0", bus.err_timeout_o,
                     bus.fb_sel_o); end
        bus.m_sel_i = 2'b00;
        step();
        bus.m_sel_i   = 2'b10;
        bus.m_wr_i[1] = 1'b0;
        step();
        total++; if (bus.fb_sel_o !== 1'b1 || bus.grant_o !== 2'd1) begin bad++;
            $display("FAIL tmo_next_grant: got sel=%0b grant=%0d want 1/1", bus.fb_sel_o,
                     bus.grant_o); end
        bus.fb_ack_i  = 1'b1;
        bus.fb_data_i = 16'hCAFE;
        step();
        total++; if (bus.m_ack_o !== 2'b10 || bus.m_data_out_o !== 16'hCAFE ||
                     bus.err_timeout_o !== 1'b1) begin bad++;
            $display("FAIL tmo_next_ack: got %b/%h err=%0b want 10/cafe/1", bus.m_ack_o,
                     bus.m_data_out_o, bus.err_timeout_o); end
        bus.fb_ack_i = 1'b0;
        bus.m_sel_i  = 2'b00;
        step();
        step();
    endtask

    task automatic test_contention();
        logic [1:0] exp_ack;
        bus.m_sel_i = 2'b11;
        bus.m_wr_i  = 2'b11;
        reset_i     = 1'b1;
        step();
        reset_i = 1'b0;
        total++; if (bus.err_timeout_o !== 1'b0) begin bad++;
            $display("FAIL cont_err_cleared: got %0b want 0", bus.err_timeout_o); end
        for (int t = 0; t < 6; t++) begin
            exp_ack = (t % 2 == 0) ? 2'b01 : 2'b10;
            step();
            total++; if (bus.fb_sel_o !== 1'b1 || bus.grant_o !== 2'(t % 2)) begin bad++;
                $display("FAIL cont_grant_%0d: got sel=%0b grant=%0d want 1/%0d", t,
                         bus.fb_sel_o, bus.grant_o, t % 2); end
            bus.fb_ack_i = 1'b1;
            step();
            total++; if (bus.m_ack_o !== exp_ack || bus.fb_sel_o !== 1'b0) begin bad++;
                $display("FAIL cont_ack_%0d: got ack=%b sel=%0b want %b/0", t, bus.m_ack_o,
                         bus.fb_sel_o, exp_ack); end
            bus.fb_ack_i = 1'b0;
            step();
            total++; if (bus.fb_sel_o !== 1'b0 || bus.m_ack_o !== 2'b00) begin bad++;
                $display("FAIL cont_release_%0d: got sel=%0b ack=%b want 0/00", t,
                         bus.fb_sel_o, bus.m_ack_o); end
        end
        bus.m_sel_i = 2'b00;
        step();
        step();
    endtask

    task automatic test_reset_mid_busy();
        bus.m_sel_i = 2'b01;
        step();
        total++; if (bus.fb_sel_o !== 1'b1 || bus.grant_o !== 2'd0) begin bad++;
            $display("FAIL rst_pre_grant: got sel=%0b grant=%0d want 1/0", bus.fb_sel_o,
                     bus.grant_o); end
        step();
        step();
        reset_i = 1'b1;
        step();
        total++; if (bus.fb_sel_o !== 1'b0 || bus.m_ack_o !== 2'b00) begin bad++;
            $display("FAIL rst_mid_busy: got sel=%0b ack=%b want 0/00", bus.fb_sel_o,
                     bus.m_ack_o); end
        reset_i      = 1'b0;
        bus.m_sel_i  = 2'b11;
        bus.fb_ack_i = 1'b1;
        step();
        total++; if (bus.m_ack_o !== 2'b00 || bus.fb_sel_o !== 1'b1 || bus.grant_o !== 2'd0)
            begin bad++;
            $display("FAIL rst_first_grant: got ack=%b sel=%0b grant=%0d want 00/1/0",
                     bus.m_ack_o, bus.fb_sel_o, bus.grant_o); end
        bus.fb_ack_i = 1'b0;
        step();
        bus.fb_ack_i = 1'b1;
        step();
        total++; if (bus.m_ack_o !== 2'b01) begin bad++;
            $display("FAIL rst_post_ack: got %b want 01", bus.m_ack_o); end
        bus.fb_ack_i = 1'b0;
        bus.m_sel_i  = 2'b00;
        step();
        step();
    endtask

    task automatic test_sel_withdrawal();
        bus.m_sel_i   = 2'b01;
        bus.m_wr_i[0] = 1'b0;
        step();
        total++; if (bus.fb_sel_o !== 1'b1 || bus.grant_o !== 2'd0) begin bad++;
            $display("FAIL wd_grant: got sel=%0b grant=%0d want 1/0", bus.fb_sel_o,
                     bus.grant_o); end
        bus.m_sel_i = 2'b00;
        step();
        step();
        total++; if (bus.fb_sel_o !== 1'b1 || bus.m_ack_o !== 2'b00) begin bad++;
            $display("FAIL wd_still_busy: got sel=%0b ack=%b want 1/00", bus.fb_sel_o,
                     bus.m_ack_o); end
        bus.fb_ack_i  = 1'b1;
        bus.fb_data_i = 16'h4321;
        step();
        total++; if (bus.m_ack_o !== 2'b01 || bus.m_data_out_o !== 16'h4321) begin bad++;
            $display("FAIL wd_ack: got %b/%h want 01/4321", bus.m_ack_o, bus.m_data_out_o); end
        bus.fb_ack_i = 1'b0;
        step();
        total++; if (bus.m_ack_o !== 2'b00) begin bad++;
            $display("FAIL wd_single_pulse: got %b want 00", bus.m_ack_o); end
        step();
        total++; if (bus.fb_sel_o !== 1'b0 || bus.m_ack_o !== 2'b00) begin bad++;
            $display("FAIL wd_no_regrant: got sel=%0b ack=%b want 0/00", bus.fb_sel_o,
                     bus.m_ack_o); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_i = 1'b1;
        test_reset();
        test_single_write();
        test_read_return();
        test_timeout();
        test_contention();
        test_reset_mid_busy();
        test_sel_withdrawal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
